// File: rtl/pulse_window_integrator_pkg.sv
// rtl/pulse_window_integrator_pkg.sv - shared widths and FSM state encoding for the pulse window integrator
package pulse_window_integrator_pkg;

    // Default widths shared by the top and the accumulator
    localparam int PWI_DIN_W = 16;
    localparam int PWI_ACC_W = 20;
    localparam int PWI_DLY_W = 8;
    localparam int PWI_LEN_W = 6;

    // Window FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_INTEG = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/pulse_window_integrator_sat_accumulator.sv
// rtl/pulse_window_integrator_sat_accumulator.sv - signed add of one sample with clamp to the accumulator range
module sat_accumulator
    import pulse_window_integrator_pkg::*;
#(
    parameter int DIN_W = PWI_DIN_W,
    parameter int ACC_W = PWI_ACC_W
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [DIN_W-1:0] din,
    output logic signed [ACC_W-1:0] acc_next,
    output logic                    sat
);

    // Most positive and most negative representable accumulator values
    localparam logic signed [ACC_W-1:0] POS_LIM = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] NEG_LIM = {1'b1, {(ACC_W-1){1'b0}}};

    // One guard bit is enough: a single sample can never overflow by more than one bit
    logic signed [ACC_W:0] wide;
    assign wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-DIN_W){din[DIN_W-1]}}, din};

    // Guard bit disagreeing with the sign bit means the true sum left the range
    always_comb begin
        sat      = 1'b0;
        acc_next = wide[ACC_W-1:0];
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sat      = 1'b1;
            acc_next = wide[ACC_W] ? NEG_LIM : POS_LIM;
        end
    end

endmodule

// File: rtl/pulse_window_integrator.sv
// rtl/pulse_window_integrator.sv - triggered delayed-window saturating integrator (optional PWI_OFLOW_GATE_EN)
module pulse_window_integrator
    import pulse_window_integrator_pkg::*;
#(
    parameter int DIN_W = PWI_DIN_W,
    parameter int ACC_W = PWI_ACC_W,
    parameter int DLY_W = PWI_DLY_W,
    parameter int LEN_W = PWI_LEN_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    trig,
    input  logic signed [DIN_W-1:0] din,
    input  logic                    oflow_in,
    input  logic        [DLY_W-1:0] delay,
    input  logic        [LEN_W-1:0] len,
    input  logic                    sat_clr,
    output logic signed [ACC_W-1:0] sum,
    output logic                    sum_valid,
    output logic                    busy,
    output logic                    sat_flag,
    output logic                    result_bad
);

    // One counter serves both the delay phase and the sample phase
    localparam int CNT_W = (DLY_W > LEN_W) ? DLY_W : LEN_W;

    logic                    trig_a;
    logic                    trig_b;
    logic                    trig_edge;
    logic                    accept;
    logic                    sampling;
    logic [1:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [LEN_W-1:0]        len_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic                    sat_pulse;

    // Trigger synchroniser-style pipeline; a rising edge shows up as trig_a & ~trig_b
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_a <= 1'b0;
            trig_b <= 1'b0;
        end else begin
            trig_a <= trig;
            trig_b <= trig_a;
        end
    end

    assign trig_edge = trig_a & ~trig_b;
    // The cycle showing the strobe still counts as busy, so a retrigger there is dropped
    assign accept    = trig_edge && (state == ST_IDLE) && !sum_valid;
    assign sampling  = (state == ST_INTEG);
    assign busy      = (state != ST_IDLE) || sum_valid;

    sat_accumulator #(
        .DIN_W (DIN_W),
        .ACC_W (ACC_W)
    ) u_sat_acc (
        .acc      (acc),
        .din      (din),
        .acc_next (acc_next),
        .sat      (sat_pulse)
    );

    // Window sequencer: latch settings on accept, count delay, then count samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            len_q <= '0;
            acc   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        len_q <= len;
                        acc   <= '0;
                        if (delay != '0) begin
                            state <= ST_DELAY;
                            cnt   <= CNT_W'(delay);
                        end else if (len != '0) begin
                            state <= ST_INTEG;
                            cnt   <= CNT_W'(len);
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt == CNT_W'(1)) begin
                        if (len_q != '0) begin
                            state <= ST_INTEG;
                            cnt   <= CNT_W'(len_q);
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_INTEG: begin
                    acc <= acc_next;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Publish the result once per window; sum holds until the next window finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                sum <= acc;
            end
        end
    end

    // Sticky saturation indicator; an explicit clear beats a coincident clamp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end else if (sampling && sat_pulse) begin
            sat_flag <= 1'b1;
        end
    end

`ifdef PWI_OFLOW_GATE_EN
    logic win_bad;

    // Remember any upstream overflow on an accumulated sample; report it alongside sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_bad    <= 1'b0;
            result_bad <= 1'b0;
        end else begin
            if (accept) begin
                win_bad <= 1'b0;
            end else if (sampling && oflow_in) begin
                win_bad <= 1'b1;
            end
            if (state == ST_DONE) begin
                result_bad <= win_bad;
            end
        end
    end
`else
    logic unused_oflow;
    assign unused_oflow = oflow_in;
    assign result_bad   = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_window_integrator.sv
// tb/tb_pulse_window_integrator.sv - randomized and directed bench for pulse_window_integrator
module tb_pulse_window_integrator;

    localparam longint AMAX = 524287;
    localparam longint AMIN = -524288;

    logic               clk;
    logic               rst_n;
    logic               trig;
    logic signed [15:0] din;
    logic               oflow_in;
    logic [7:0]         delay;
    logic [5:0]         len;
    logic               sat_clr;
    logic signed [19:0] sum;
    logic               sum_valid;
    logic               busy;
    logic               sat_flag;
    logic               result_bad;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // stimulus controls
    int din_mode = 0;   // 0 hold, 1 ramp, 2 random
    int din_bias = 0;   // 0 full range, 1 large positive, 2 large negative
    bit rnd_side = 0;

    // model state
    bit     m_act = 0;
    int     m_E = 0, m_d = 0, m_l = 0, m_V = 0;
    longint m_acc = 0;
    bit     m_bad = 0;
    longint e_sum = 0;
    bit     e_sat = 0;
    bit     e_bad = 0;
    bit     ta = 0, tb = 0;

    pulse_window_integrator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig       (trig),
        .din        (din),
        .oflow_in   (oflow_in),
        .delay      (delay),
        .len        (len),
        .sat_clr    (sat_clr),
        .sum        (sum),
        .sum_valid  (sum_valid),
        .busy       (busy),
        .sat_flag   (sat_flag),
        .result_bad (result_bad)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    // Behavioural reference: window bookkeeping in absolute cycle numbers
    initial begin
        int     n;
        bit     clamp;
        bit     exp_busy;
        bit     exp_valid;
        forever begin
            @(negedge clk);
            n = cyc;
            if (!rst_n) begin
                m_act = 0; m_acc = 0; m_bad = 0;
                e_sum = 0; e_sat = 0; e_bad = 0;
                ta = 0; tb = 0;
            end
            exp_busy  = m_act && (n >= m_E + 1) && (n <= m_V);
            exp_valid = m_act && (n == m_V);
            chk("sum_valid",  longint'(sum_valid),  longint'(exp_valid));
            chk("busy",       longint'(busy),       longint'(exp_busy));
            chk("sum",        longint'(sum),        e_sum);
            chk("sat_flag",   longint'(sat_flag),   longint'(e_sat));
            chk("result_bad", longint'(result_bad), longint'(e_bad));
            if (rst_n) begin
                clamp = 0;
                if (ta && !tb && (!m_act || n > m_V)) begin
                    m_act = 1; m_E = n; m_d = int'(delay); m_l = int'(len);
                    m_V = n + m_d + m_l + 2;
                    m_acc = 0; m_bad = 0;
                end
                if (m_act && n >= m_E + m_d + 1 && n <= m_E + m_d + m_l) begin
                    m_acc = m_acc + longint'(din);
                    if (m_acc > AMAX) begin m_acc = AMAX; clamp = 1; end
                    if (m_acc < AMIN) begin m_acc = AMIN; clamp = 1; end
                    if (oflow_in) m_bad = 1;
                end
                e_sat = sat_clr ? 1'b0 : (e_sat | clamp);
                if (m_act && n + 1 == m_V) begin
                    e_sum = m_acc;
`ifdef PWI_OFLOW_GATE_EN
                    e_bad = m_bad;
`else
                    e_bad = 0;
`endif
                end
                tb = ta;
                ta = trig;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (din_mode)
            1: din = din + 16'sd1;
            2: begin
                case (din_bias)
                    1:       din = 16'($urandom_range(20000, 32767));
                    2:       din = -16'($urandom_range(20000, 32768));
                    default: din = 16'($urandom);
                endcase
            end
            default: ;
        endcase
        if (rnd_side) begin
            oflow_in = ($urandom_range(0, 15) == 0);
            sat_clr  = ($urandom_range(0, 31) == 0);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    // Raise trig for two cycles; returns in cycle E+1 with trig low
    task automatic fire(input int d, input int l);
        delay = 8'(d);
        len   = 6'(l);
        trig  = 1'b1;
        step();
        step();
        trig  = 1'b0;
    endtask

    initial begin
        int e0;
        rst_n = 1'b0; trig = 1'b0; din = '0; oflow_in = 1'b0;
        delay = '0; len = '0; sat_clr = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(3);

        // constant 100 over 4 samples, no delay
        din = 16'sd100; din_mode = 0;
        fire(0, 4);
        chk("lit_lat_A", longint'(m_V - m_E), 6);
        idle(8);
        chk("lit_sum_A", e_sum, 400);
        chk("lit_sat_A", longint'(e_sat), 0);

        // ramp starting at E+1, delay 3 and two samples
        fire(3, 2);
        din = 16'sd1; din_mode = 1;
        delay = 8'd50; len = 6'd33;
        idle(8);
        din_mode = 0;
        chk("lit_sum_B", e_sum, 9);

        // positive saturation, clear, then negative saturation
        din = 16'sd32767;
        fire(0, 63);
        idle(66);
        chk("lit_sum_Cp", e_sum, AMAX);
        chk("lit_sat_Cp", longint'(e_sat), 1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        step();
        chk("lit_sat_clr", longint'(e_sat), 0);
        din = -16'sd32768;
        fire(0, 63);
        idle(66);
        chk("lit_sum_Cn", e_sum, AMIN);
        chk("lit_sat_Cn", longint'(e_sat), 1);

        // mid-window retrigger ignored, retrigger on first idle cycle accepted
        din = 16'sd1;
        fire(0, 10);
        e0 = m_E;
        step(); step();
        trig = 1'b1;
        step(); step();
        trig = 1'b0;
        while (cyc < e0 + 12) step();
        chk("lit_sum_D", e_sum, 10);
        trig = 1'b1;
        step(); step();
        trig = 1'b0;
        chk("lit_retrig", longint'(m_E - e0), 13);
        idle(14);
        chk("lit_sum_D2", e_sum, 10);

        // reset in the middle of integration, then fresh windows
        fire(0, 20);
        idle(4);
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        idle(5);
        din_mode = 2;
        fire(2, 5);
        idle(12);
        din_mode = 0;
        din = 16'sd7;
        fire(3, 0);
        chk("lit_lat_len0", longint'(m_V - m_E), 5);
        idle(8);
        chk("lit_sum_len0", e_sum, 0);

        // upstream overflow on one accumulated sample, then a clean window
        din = 16'sd5;
        fire(1, 3);
        step();
        oflow_in = 1'b1;
        step();
        oflow_in = 1'b0;
        idle(6);
        chk("lit_sum_ofl", e_sum, 15);
`ifdef PWI_OFLOW_GATE_EN
        chk("lit_bad_set", longint'(e_bad), 1);
`else
        chk("lit_bad_set", longint'(e_bad), 0);
`endif
        fire(1, 3);
        idle(8);
        chk("lit_bad_clean", longint'(e_bad), 0);

        // randomized windows with stray triggers and setting changes
        din_mode = 2;
        rnd_side = 1;
        for (int w = 0; w < 40; w++) begin
            int d;
            int l;
            int span;
            din_bias = $urandom_range(0, 2);
            d = $urandom_range(0, 12);
            l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
            fire(d, l);
            span = $urandom_range(0, d + l + 6);
            for (int k = 0; k < span; k++) begin
                step();
                trig = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 9) == 0) begin
                    delay = 8'($urandom);
                    len   = 6'($urandom);
                end
            end
            trig = 1'b0;
            idle($urandom_range(0, 3));
        end
        rnd_side = 0;
        oflow_in = 1'b0;
        sat_clr  = 1'b0;
        trig     = 1'b0;
        idle(90);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_window_integrator.md
Name: pulse_window_integrator

Overview:
Downstream consumer of the anti-droop IIR stage. On each trigger rising edge it waits a programmable number of cycles, then sums a programmable number of droop-corrected 16-bit samples into a saturating accumulator. It presents one signed sum per trigger with a single-cycle valid strobe for the feedback/readout logic.

Parameters:
DIN_W, 16, width of signed input sample (matches IIR stage dout)
ACC_W, 20, width of signed accumulator and sum output
DLY_W, 8, width of delay setting
LEN_W, 6, width of window length setting

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
trig  input  1  trigger (same trigger that feeds the IIR stage); level, rising edge used
din  input  DIN_W  signed droop-corrected sample
oflow_in  input  1  IIR overflow flag, aligned with din
delay  input  DLY_W  cycles from trigger edge to first sample
len  input  LEN_W  number of samples to integrate
sat_clr  input  1  clears sticky sat_flag
sum  output  ACC_W  signed integrated result, held until next result
sum_valid  output  1  one-cycle strobe, sum updated this cycle
busy  output  1  high from trigger edge until sum_valid cycle inclusive
sat_flag  output  1  sticky: an accumulation saturated
result_bad  output  1  qualifies sum (see Optional Feature); 0 when feature is absent

Behaviour:
- Reset (async, rst_n=0): state IDLE; sum=0, sum_valid=0, busy=0, sat_flag=0, result_bad=0; counters and accumulator 0; trig pipeline regs 0.
- Trigger: two registers trig_a<=trig, trig_b<=trig_a; edge = trig_a & ~trig_b. Edge cycle is E.
- In E, from IDLE: latch delay and len; clear acc; busy=1 from E+1. Later changes to delay/len do not affect the running window.
- States: IDLE -> DELAY (edge, delay>0) | INTEG (edge, delay=0, len>0) | DONE (edge, delay=0, len=0); DELAY -> INTEG after delay cycles (or DONE if len=0); INTEG -> DONE after len samples; DONE -> IDLE.
- First sample is din registered at the clock edge ending cycle E+delay+1. Then one sample per cycle, len samples contiguous.
- Accumulate: acc_next = acc + sign-extended din, computed at ACC_W+1 bits. If the result exceeds +2^(ACC_W-1)-1, clamp to that value. If it is below -2^(ACC_W-1), clamp to that value. Clamping sets sat_flag. Later samples continue from the clamped value.
- DONE cycle: sum<=acc, sum_valid=1 for exactly one cycle, busy still 1. Next cycle IDLE, busy=0.
- len=0: sum=0 with valid, no samples taken.
- Latency: sum_valid is asserted in cycle E+delay+len+2.
- Trigger edges while busy are ignored (not queued). An edge in the same cycle as the DONE->IDLE transition is also ignored. The earliest accepted retrigger is on the first IDLE cycle.
- sat_flag: sat_clr has priority over a simultaneous set (clear wins); the flag is sticky otherwise.
- sum holds its last value between results; only DONE updates it.

Optional Feature:
Macro PWI_OFLOW_GATE_EN.
- Defined: any oflow_in=1 on a cycle whose sample is accumulated sets an internal window flag. result_bad <= flag at DONE, held with sum. The flag is cleared on trigger acceptance.
- Undefined: oflow_in is ignored and result_bad is tied to 0.

Decomposition:
- Shared package: state encoding constants (IDLE=0, DELAY=1, INTEG=2, DONE=3), saturation limit helper constants derived from ACC_W.
- One natural sub-module: sat_accumulator (signed add with clamp and sat pulse output). The FSM and counters stay in the top module.

Test Plan:
- delay=0, len=4, din=100 constant, one trig -> sum=400, sum_valid at E+6, busy E+1..E+6, sat_flag=0.
- delay=3, len=2, din ramps 1,2,3,... each cycle from E+1 -> sum=4+5=9 (samples at E+4, E+5).
- din=32767, len=63, delay=0 -> sum=524287, sat_flag=1. sat_clr pulse -> sat_flag=0. Next window with din=-32768, len=63 -> sum=-524288, sat_flag=1.
- Second trig edge mid-window (delay=0, len=10, din=1) -> single sum=10, only one valid. A trig edge on the first IDLE cycle starts a new window.
- rst_n low during INTEG -> all outputs 0 immediately. After release, no stray valid; a fresh trig gives a correct sum. len=0 -> sum=0, valid at E+delay+2.
- With PWI_OFLOW_GATE_EN: oflow_in=1 on one in-window sample -> result_bad=1. Next clean window -> result_bad=0. Without the macro, result_bad is always 0.
